// File: rtl/life_sequencer_if.sv
// Link between the generation controller and the 16x16 cell array.
// The controller drives the edit/tick/clear strobes; the array returns its cell states.
interface life_sequencer_if;
  logic [15:0][15:0] board;
  logic              edit_we;
  logic [3:0]        edit_row;
  logic [3:0]        edit_col;
  logic              gen_tick;
  logic              clear_out;

  modport master (
    input  board,
    output edit_we, edit_row, edit_col, gen_tick, clear_out
  );

  modport slave (
    output board,
    input  edit_we, edit_row, edit_col, gen_tick, clear_out
  );
endinterface

// File: rtl/life_sequencer.sv
// Game of Life generation controller: edit cursor, toggle writes, run/step ticks,
// board clear, generation counter and extinct/stable detection with auto-halt.
module life_sequencer #(
  parameter int TICK_DIV  = 25000000,
  parameter int CNT_W     = 16,
  parameter bit AUTO_HALT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic             cur_up_i,
  input  logic             cur_down_i,
  input  logic             cur_left_i,
  input  logic             cur_right_i,
  input  logic             toggle_i,
  output logic [3:0]       cursor_row_o,
  output logic [3:0]       cursor_col_o,
  output logic [CNT_W-1:0] gen_count_o,
  output logic             extinct_o,
  output logic             stable_o,
  output logic [1:0]       mode_o,
  life_sequencer_if.master grid
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_EDIT  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [3:0]        row_q, row_d, col_q, col_d;
  logic [3:0]        erow_q, erow_d, ecol_q, ecol_d;
  logic              we_q, we_d, tick_q, tick_d, clr_q, clr_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              ext_q, ext_d, stb_q, stb_d;
  logic [15:0][15:0] prev_q, prev_d;
  logic [1:0]        chk_q, chk_d;
  logic              armed_q, armed_d;
  logic              board_zero, board_same, halt;

  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign board_zero = (grid.board == '0);
  assign board_same = (grid.board == prev_q);
  // chk_q[1] marks the cycle two clocks after a tick, when the array has settled.
  assign halt       = AUTO_HALT && chk_q[1] && (board_zero || board_same);

  always_comb begin
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    erow_d  = erow_q;
    ecol_d  = ecol_q;
    we_d    = 1'b0;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    stb_d   = stb_q;
    armed_d = armed_q | ~run_i;
    prev_d  = tick_q ? grid.board : prev_q;
    chk_d   = {chk_q[0], tick_q};
    if (chk_q[1]) begin
      ext_d = board_zero;
      stb_d = board_same;
    end

    if (clear_i) begin
      mode_d  = MODE_CLEAR;
      clr_d   = 1'b1;
      cnt_d   = '0;
      ext_d   = 1'b0;
      stb_d   = 1'b0;
      chk_d   = 2'b00;
      presc_d = '0;
    end else begin
      unique case (mode_q)
        MODE_EDIT: begin
          if (cur_down_i && !cur_up_i)         row_d = row_q + 4'd1;
          else if (cur_up_i && !cur_down_i)    row_d = row_q - 4'd1;
          if (cur_right_i && !cur_left_i)      col_d = col_q + 4'd1;
          else if (cur_left_i && !cur_right_i) col_d = col_q - 4'd1;
          if (toggle_i) begin
            we_d   = 1'b1;
            erow_d = row_q;
            ecol_d = col_q;
          end
          if (run_i && armed_q) begin
            mode_d  = MODE_RUN;
            presc_d = '0;
          end else if (step_i) begin
            mode_d = MODE_STEP;
            tick_d = 1'b1;
            cnt_d  = cnt_inc;
          end
        end
        MODE_RUN: begin
          if (!run_i) begin
            mode_d  = MODE_EDIT;
            presc_d = '0;
          end else if (halt) begin
            // Stay out of RUN until run is released and pressed again.
            mode_d  = MODE_EDIT;
            presc_d = '0;
            armed_d = 1'b0;
          end else if (presc_q == PMAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            cnt_d   = cnt_inc;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        MODE_STEP:  mode_d = MODE_EDIT;
        MODE_CLEAR: mode_d = MODE_EDIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_EDIT;
      row_q   <= '0;
      col_q   <= '0;
      erow_q  <= '0;
      ecol_q  <= '0;
      we_q    <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
      ext_q   <= 1'b0;
      stb_q   <= 1'b0;
      prev_q  <= '0;
      chk_q   <= 2'b00;
      armed_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      erow_q  <= erow_d;
      ecol_q  <= ecol_d;
      we_q    <= we_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      stb_q   <= stb_d;
      prev_q  <= prev_d;
      chk_q   <= chk_d;
      armed_q <= armed_d;
    end
  end

  assign cursor_row_o   = row_q;
  assign cursor_col_o   = col_q;
  assign gen_count_o    = cnt_q;
  assign extinct_o      = ext_q;
  assign stable_o       = stb_q;
  assign mode_o         = mode_q;
  assign grid.edit_we   = we_q;
  assign grid.edit_row  = erow_q;
  assign grid.edit_col  = ecol_q;
  assign grid.gen_tick  = tick_q;
  assign grid.clear_out = clr_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a small behavioural cell array attached.
module tb_life_sequencer;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, clr = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, tog = 1'b0;
  logic [3:0]  cursor_row, cursor_col;
  logic [15:0] gen_count;
  logic        extinct, stable;
  logic [1:0]  mode;
  logic [15:0][15:0] board_q = '0;
  logic [15:0][15:0] load_val = '0;
  logic        load_en = 1'b0;
  int vectors = 0, miscompares = 0;

  life_sequencer_if g ();
  assign g.board = board_q;

  life_sequencer #(.TICK_DIV(4), .CNT_W(16), .AUTO_HALT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .clear_i(clr),
    .cur_up_i(up), .cur_down_i(down), .cur_left_i(left), .cur_right_i(right),
    .toggle_i(tog), .cursor_row_o(cursor_row), .cursor_col_o(cursor_col),
    .gen_count_o(gen_count), .extinct_o(extinct), .stable_o(stable),
    .mode_o(mode), .grid(g)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0][15:0] life_next(input logic [15:0][15:0] b);
    logic [15:0][15:0] n;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 16 &&
                c + dc >= 0 && c + dc < 16 && b[r+dr][c+dc])
              cnt++;
        n[r][c] = b[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  // Cell array stand-in: reacts to the controller strobes.
  always @(posedge clk) begin
    if (load_en)          board_q <= load_val;
    else if (g.clear_out) board_q <= '0;
    else if (g.gen_tick)  board_q <= life_next(board_q);
    else if (g.edit_we)   board_q[g.edit_row][g.edit_col] <= ~board_q[g.edit_row][g.edit_col];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    $display("reset: mode=%0d row=%0d col=%0d count=%0d", mode, cursor_row, cursor_col, gen_count);
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode: got %0d want 0", mode); end
    vectors++; if ({cursor_row, cursor_col} !== 8'h00) begin miscompares++; $display("FAIL reset_cursor: got %0d/%0d want 0/0", cursor_row, cursor_col); end
    vectors++; if (gen_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", gen_count); end
    vectors++; if ({g.edit_we, g.gen_tick, g.clear_out, extinct, stable} !== 5'b0) begin miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {g.edit_we, g.gen_tick, g.clear_out, extinct, stable}); end
    vectors++; if ({g.edit_row, g.edit_col} !== 8'h00) begin miscompares++; $display("FAIL reset_edit_addr: got %0d/%0d want 0/0", g.edit_row, g.edit_col); end
  endtask

  task automatic test_cursor();
    for (int i = 0; i < 17; i++) begin right = 1'b1; cyc(); right = 1'b0; end
    up = 1'b1; cyc(); up = 1'b0;
    $display("cursor: row=%0d col=%0d", cursor_row, cursor_col);
    vectors++; if (cursor_col !== 4'd1) begin miscompares++; $display("FAIL cursor_col_wrap: got %0d want 1", cursor_col); end
    vectors++; if (cursor_row !== 4'd15) begin miscompares++; $display("FAIL cursor_row_wrap: got %0d want 15", cursor_row); end
    left = 1'b1; right = 1'b1; up = 1'b1; down = 1'b1; cyc();
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    $display("cursor cancel: row=%0d col=%0d", cursor_row, cursor_col);
    vectors++; if ({cursor_row, cursor_col} !== {4'd15, 4'd1}) begin miscompares++;
      $display("FAIL cursor_cancel: got %0d/%0d want 15/1", cursor_row, cursor_col); end
  endtask

  task automatic test_toggle();
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin down = 1'b1; cyc(); down = 1'b0; end
    for (int i = 0; i < 5; i++) begin right = 1'b1; cyc(); right = 1'b0; end
    tog = 1'b1; down = 1'b1; cyc(); tog = 1'b0; down = 1'b0;
    $display("toggle: we=%0b addr=%0d/%0d cursor_row=%0d", g.edit_we, g.edit_row, g.edit_col, cursor_row);
    vectors++; if (g.edit_we !== 1'b1) begin miscompares++; $display("FAIL toggle_we: got %0b want 1", g.edit_we); end
    vectors++; if ({g.edit_row, g.edit_col} !== {4'd3, 4'd5}) begin miscompares++;
      $display("FAIL toggle_addr: got %0d/%0d want 3/5", g.edit_row, g.edit_col); end
    vectors++; if (cursor_row !== 4'd4) begin miscompares++; $display("FAIL toggle_cursor_move: got %0d want 4", cursor_row); end
    cyc();
    vectors++; if (g.edit_we !== 1'b0) begin miscompares++; $display("FAIL toggle_single_strobe: got %0b want 0", g.edit_we); end
  endtask

  task automatic test_auto_halt();
    int ticks, first;
    ticks = 0; first = 0;
    run = 1'b1; cyc();
    vectors++; if (mode !== 2'd1) begin miscompares++; $display("FAIL halt_enter_run: got %0d want 1", mode); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (g.gen_tick === 1'b1) begin ticks++; if (first == 0) first = i; end
      if (i == 6) begin
        vectors++; if (mode !== 2'd1) begin miscompares++; $display("FAIL halt_early: got mode %0d want 1 at cycle 6", mode); end
      end
      if (i == 7) begin
        vectors++; if ({extinct, mode} !== 3'b100) begin miscompares++;
          $display("FAIL halt_extinct: got extinct=%0b mode=%0d want 1/0", extinct, mode); end
      end
    end
    $display("auto-halt: ticks=%0d first=%0d count=%0d mode=%0d", ticks, first, gen_count, mode);
    vectors++; if (ticks != 1 || first != 4) begin miscompares++;
      $display("FAIL halt_tick_pattern: got %0d ticks first at %0d want 1 at 4", ticks, first); end
    vectors++; if (gen_count !== 16'd1) begin miscompares++; $display("FAIL halt_count: got %0d want 1", gen_count); end
    run = 1'b0; cyc(); run = 1'b1; cyc();
    vectors++; if (mode !== 2'd1) begin miscompares++; $display("FAIL halt_rearm: got %0d want 1", mode); end
    run = 1'b0; cyc();
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL run_release: got %0d want 0", mode); end
  endtask

  task automatic test_step();
    step = 1'b1; cyc(); step = 1'b0;
    $display("step: mode=%0d tick=%0b count=%0d", mode, g.gen_tick, gen_count);
    vectors++; if ({mode, g.gen_tick} !== 3'b101) begin miscompares++;
      $display("FAIL step_state: got mode=%0d tick=%0b want 2/1", mode, g.gen_tick); end
    vectors++; if (gen_count !== 16'd2) begin miscompares++; $display("FAIL step_count: got %0d want 2", gen_count); end
    cyc();
    vectors++; if ({mode, g.gen_tick} !== 3'b000) begin miscompares++;
      $display("FAIL step_return: got mode=%0d tick=%0b want 0/0", mode, g.gen_tick); end
    cyc(); cyc(); cyc();
    run = 1'b1; step = 1'b1; cyc(); cyc(); step = 1'b0;
    $display("step in run: mode=%0d tick=%0b count=%0d", mode, g.gen_tick, gen_count);
    vectors++; if ({mode, g.gen_tick, gen_count} !== {2'd1, 1'b0, 16'd2}) begin miscompares++;
      $display("FAIL step_in_run: got mode=%0d tick=%0b count=%0d want 1/0/2", mode, g.gen_tick, gen_count); end
    run = 1'b0; cyc();
  endtask

  task automatic test_run_clear();
    int tick_err, mode_err;
    tick_err = 0; mode_err = 0;
    clr = 1'b1; cyc(); clr = 1'b0;
    $display("clear: clear_out=%0b mode=%0d count=%0d", g.clear_out, mode, gen_count);
    vectors++; if ({g.clear_out, mode, gen_count, extinct, stable} !== {1'b1, 2'd3, 16'd0, 2'b00}) begin miscompares++;
      $display("FAIL clear_edit: got clr=%0b mode=%0d count=%0d ext=%0b stb=%0b want 1/3/0/0/0",
               g.clear_out, mode, gen_count, extinct, stable); end
    cyc();
    vectors++; if ({g.clear_out, mode} !== 3'b000) begin miscompares++;
      $display("FAIL clear_return: got clr=%0b mode=%0d want 0/0", g.clear_out, mode); end
    load_val = '0; load_val[7][6] = 1'b1; load_val[7][7] = 1'b1; load_val[7][8] = 1'b1;
    load_en = 1'b1; cyc(); load_en = 1'b0;
    run = 1'b1; cyc();
    for (int i = 1; i <= 31; i++) begin
      cyc();
      if (g.gen_tick !== ((i % 4) == 0)) tick_err++;
      if (mode !== 2'd1) mode_err++;
      if (i == 20) begin
        $display("run: count=%0d stable=%0b extinct=%0b mode=%0d", gen_count, stable, extinct, mode);
        vectors++; if ({gen_count, stable, extinct} !== {16'd5, 2'b00}) begin miscompares++;
          $display("FAIL run_blinker: got count=%0d stb=%0b ext=%0b want 5/0/0", gen_count, stable, extinct); end
      end
    end
    vectors++; if (tick_err != 0 || mode_err != 0) begin miscompares++;
      $display("FAIL run_cadence: got %0d tick errors %0d mode errors want 0/0", tick_err, mode_err); end
    vectors++; if (gen_count !== 16'd7) begin miscompares++; $display("FAIL run_count7: got %0d want 7", gen_count); end
    clr = 1'b1; run = 1'b0; cyc(); clr = 1'b0;
    $display("clear at wrap: clear_out=%0b tick=%0b count=%0d mode=%0d", g.clear_out, g.gen_tick, gen_count, mode);
    vectors++; if ({g.clear_out, g.gen_tick, gen_count, extinct, stable} !== {2'b10, 16'd0, 2'b00}) begin miscompares++;
      $display("FAIL clear_wrap: got clr=%0b tick=%0b count=%0d ext=%0b stb=%0b want 1/0/0/0/0",
               g.clear_out, g.gen_tick, gen_count, extinct, stable); end
    cyc();
    vectors++; if ({mode, g.gen_tick, gen_count} !== {2'd0, 1'b0, 16'd0}) begin miscompares++;
      $display("FAIL clear_wrap_after: got mode=%0d tick=%0b count=%0d want 0/0/0", mode, g.gen_tick, gen_count); end
  endtask

  task automatic test_reset_mid_run();
    load_en = 1'b1; cyc(); load_en = 1'b0;
    run = 1'b1; cyc();
    for (int i = 0; i < 10; i++) cyc();
    vectors++; if ({mode, gen_count} !== {2'd1, 16'd2}) begin miscompares++;
      $display("FAIL midrun_pre: got mode=%0d count=%0d want 1/2", mode, gen_count); end
    rst = 1'b1; cyc(); rst = 1'b0; run = 1'b0;
    $display("reset mid-run: mode=%0d count=%0d cursor=%0d/%0d", mode, gen_count, cursor_row, cursor_col);
    vectors++; if ({mode, gen_count, cursor_row, cursor_col, g.edit_row, g.edit_col} !== 34'd0) begin miscompares++;
      $display("FAIL midrun_reset_regs: got mode=%0d count=%0d cur=%0d/%0d edit=%0d/%0d want all 0",
               mode, gen_count, cursor_row, cursor_col, g.edit_row, g.edit_col); end
    vectors++; if ({g.edit_we, g.gen_tick, g.clear_out, extinct, stable} !== 5'b0) begin miscompares++;
      $display("FAIL midrun_reset_flags: got %b want 00000", {g.edit_we, g.gen_tick, g.clear_out, extinct, stable}); end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_toggle();
    test_auto_halt();
    test_step();
    test_run_clear();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
